// File: rtl/trap_pkg.sv
// trap_pkg: shared FSM state type, cause codes and CSR field constants
// for machine-mode trap sequencing.
package trap_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        ENTER,
        RETURN,
        REDIRECT
    } state_t;

    localparam logic [3:0] SSI     = 4'd1;
    localparam logic [3:0] MSI     = 4'd3;
    localparam logic [3:0] STI     = 4'd5;
    localparam logic [3:0] MTI     = 4'd7;
    localparam logic [3:0] SEI     = 4'd9;
    localparam logic [3:0] MEI     = 4'd11;
    localparam logic [3:0] ECALL_M = 4'd11;

    // Interrupt priority, highest first; unnamed causes follow lowest index first.
    localparam logic [3:0] IRQ_ORDER [16] = '{
        MEI, MSI, MTI, SEI, SSI, STI,
        4'd0, 4'd2, 4'd4, 4'd6, 4'd8, 4'd10, 4'd12, 4'd13, 4'd14, 4'd15
    };

    localparam logic [1:0] MTVEC_VECTORED = 2'b01;
    localparam int         MSTATUS_MIE    = 3;

endpackage

// File: rtl/trap_priority_encoder.sv
// trap_priority_encoder: picks one trap cause; exceptions (lowest index)
// beat interrupts (fixed priority order).
module trap_priority_encoder
    import trap_pkg::*;
(
    input  logic [15:0] excReq,
    input  logic [15:0] irqMasked,
    input  logic        takeIrq,
    output logic        valid,
    output logic        isIrq,
    output logic [3:0]  cause
);

    logic [3:0] excCause;
    logic [3:0] irqCause;

    // Scan from lowest priority up so the highest-priority hit is written last.
    always_comb begin
        excCause = '0;
        irqCause = '0;
        for (int i = 15; i >= 0; i--) begin
            excCause = excReq[i] ? 4'(i) : excCause;
            irqCause = irqMasked[IRQ_ORDER[i]] ? IRQ_ORDER[i] : irqCause;
        end
    end

    assign isIrq = ~|excReq;
    assign valid = |excReq || (takeIrq && |irqMasked);
    assign cause = isIrq ? irqCause : excCause;

endmodule

// File: rtl/trap_controller.sv
// trap_controller: sequences machine-mode trap entry (flush, CSR update,
// vector redirect) and mret return; every output is registered.
module trap_controller
    import trap_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [15:0]  excReq,
    input  logic [N-1:0] excPC,
    input  logic [N-1:0] nextPC,
    input  logic [15:0]  irqPending,
    input  logic [15:0]  irqEnable,
    input  logic [N-1:0] mstatus,
    input  logic [1:0]   currentMode,
    input  logic [N-1:0] mtvec,
    input  logic [N-1:0] mepcIn,
    input  logic         mretReq,
    input  logic         redirectAck,
    output logic         busy,
    output logic         flush,
    output logic [15:0]  trapTrigger,
    output logic         trapReturn,
    output logic         mepcWrite,
    output logic [N-1:0] mepcOut,
    output logic         mcauseWrite,
    output logic [N-1:0] mcauseOut,
    output logic         redirectValid,
    output logic [N-1:0] redirectPC
);

    state_t       state, stateNext;
    logic [3:0]   cause, causeNext;
    logic         isIrq, isIrqNext;
    logic [N-1:0] epc, epcNext;
    logic [N-1:0] target, targetNext;

    logic         busyNext, flushNext, trapReturnNext, mepcWriteNext, mcauseWriteNext, redirectValidNext;
    logic [15:0]  trapTriggerNext;
    logic [N-1:0] mepcOutNext, mcauseOutNext, redirectPCNext;

    logic         takeIrq, selValid, selIsIrq;
    logic [3:0]   selCause;
    logic [15:0]  irqMasked;
    logic [N-1:0] base, vecTarget;
    logic         unusedOk;

    assign irqMasked = irqPending & irqEnable;
    assign takeIrq   = |irqMasked && (currentMode != 2'b11 || mstatus[MSTATUS_MIE]);
    assign base      = {mtvec[N-1:2], 2'b00};
    assign vecTarget = (mtvec[1:0] == MTVEC_VECTORED && isIrq) ? base + {{(N-6){1'b0}}, cause, 2'b00} : base;
    assign unusedOk  = ^{mstatus[N-1:MSTATUS_MIE+1], mstatus[MSTATUS_MIE-1:0], epc[1:0]};

    trap_priority_encoder u_prio (
        .excReq    (excReq),
        .irqMasked (irqMasked),
        .takeIrq   (takeIrq),
        .valid     (selValid),
        .isIrq     (selIsIrq),
        .cause     (selCause)
    );

    // Next-state logic also produces next-cycle output values so that all
    // outputs come straight from flops.
    always_comb begin
        stateNext         = state;
        causeNext         = cause;
        isIrqNext         = isIrq;
        epcNext           = epc;
        targetNext        = target;
        busyNext          = 1'b0;
        flushNext         = 1'b0;
        trapTriggerNext   = '0;
        trapReturnNext    = 1'b0;
        mepcWriteNext     = 1'b0;
        mepcOutNext       = '0;
        mcauseWriteNext   = 1'b0;
        mcauseOutNext     = '0;
        redirectValidNext = 1'b0;
        redirectPCNext    = '0;
        case (state)
            IDLE: begin
                if (selValid) begin
                    stateNext = FLUSH;
                    causeNext = selCause;
                    isIrqNext = selIsIrq;
                    epcNext   = selIsIrq ? nextPC : excPC;
                    flushNext = 1'b1;
                    busyNext  = 1'b1;
                end else if (mretReq) begin
                    stateNext      = RETURN;
                    targetNext     = mepcIn;
                    trapReturnNext = 1'b1;
                    flushNext      = 1'b1;
                    busyNext       = 1'b1;
                end
            end
            FLUSH: begin
                stateNext       = ENTER;
                busyNext        = 1'b1;
                trapTriggerNext = 16'(1) << cause;
                mepcWriteNext   = 1'b1;
                mepcOutNext     = {epc[N-1:2], 2'b00};
                mcauseWriteNext = 1'b1;
                mcauseOutNext   = {isIrq, {(N-5){1'b0}}, cause};
            end
            ENTER: begin
                stateNext         = REDIRECT;
                targetNext        = vecTarget;
                busyNext          = 1'b1;
                redirectValidNext = 1'b1;
                redirectPCNext    = vecTarget;
            end
            RETURN: begin
                stateNext         = REDIRECT;
                busyNext          = 1'b1;
                redirectValidNext = 1'b1;
                redirectPCNext    = target;
            end
            REDIRECT: begin
                stateNext         = redirectAck ? IDLE : REDIRECT;
                busyNext          = ~redirectAck;
                redirectValidNext = ~redirectAck;
                redirectPCNext    = redirectAck ? '0 : target;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            cause         <= '0;
            isIrq         <= 1'b0;
            epc           <= '0;
            target        <= '0;
            busy          <= 1'b0;
            flush         <= 1'b0;
            trapTrigger   <= '0;
            trapReturn    <= 1'b0;
            mepcWrite     <= 1'b0;
            mepcOut       <= '0;
            mcauseWrite   <= 1'b0;
            mcauseOut     <= '0;
            redirectValid <= 1'b0;
            redirectPC    <= '0;
        end else begin
            state         <= stateNext;
            cause         <= causeNext;
            isIrq         <= isIrqNext;
            epc           <= epcNext;
            target        <= targetNext;
            busy          <= busyNext;
            flush         <= flushNext;
            trapTrigger   <= trapTriggerNext;
            trapReturn    <= trapReturnNext;
            mepcWrite     <= mepcWriteNext;
            mepcOut       <= mepcOutNext;
            mcauseWrite   <= mcauseWriteNext;
            mcauseOut     <= mcauseOutNext;
            redirectValid <= redirectValidNext;
            redirectPC    <= redirectPCNext;
        end
    end

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Sequences machine-mode trap entry and return for the core.
- Arbitrates pending synchronous exceptions and interrupts into a single cause, flushes and stalls the pipeline, and pulses core_status (trapTrigger/trapReturn).
- Writes mepc/mcause and redirects fetch to the mtvec handler on entry, or to mepc on mret.
- Sits between the pipeline control, the CSR file and core_status.

Parameters:
- N, 64, datapath/CSR width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- excReq  in  16  pending synchronous exception causes, one bit per cause code; level, held by pipeline while stalled.
- excPC  in  N  PC of the faulting instruction.
- nextPC  in  N  PC of the next unexecuted instruction, used as mepc for interrupts.
- irqPending  in  16  mip bits.
- irqEnable  in  16  mie CSR bits.
- mstatus  in  N  from core_status; bit 3 = MIE.
- currentMode  in  2  from core_status; 2'b11 = M.
- mtvec  in  N  trap vector CSR.
- mepcIn  in  N  current mepc CSR.
- mretReq  in  1  mret in commit stage.
- redirectAck  in  1  fetch accepted the redirect.
- busy  out  1  stall the pipeline.
- flush  out  1  squash in-flight instructions.
- trapTrigger  out  16  one-hot cause pulse to core_status.
- trapReturn  out  1  pulse to core_status.
- mepcWrite  out  1  mepc write strobe.
- mepcOut  out  N  mepc write data.
- mcauseWrite  out  1  mcause write strobe.
- mcauseOut  out  N  mcause write data.
- redirectValid  out  1  fetch redirect request.
- redirectPC  out  N  redirect target.

Behaviour:
- All outputs are registered.
- On reset low at a clk edge: state=IDLE, all outputs 0. This applies mid-sequence too: the sequence is abandoned with no partial strobes afterwards.
- Interrupt take condition: takeIrq = |(irqPending & irqEnable) && (currentMode!=2'b11 || mstatus[3]).
- Exception selection: among excReq bits, the lowest index wins.
- Interrupt selection: fixed order 11, 3, 7, 9, 1, 5, then remaining bits lowest index first.
- Exceptions have priority over interrupts. An exception or interrupt has priority over mretReq in the same cycle; the mret is dropped.
- FSM states: IDLE, FLUSH, ENTER, RETURN, REDIRECT.
- IDLE:
  - If excReq!=0: latch cause, isIrq=0, epc=excPC; go FLUSH.
  - Else if takeIrq: latch cause, isIrq=1, epc=nextPC; go FLUSH.
  - Else if mretReq: latch target=mepcIn; go RETURN.
  - busy=0.
- FLUSH (1 cycle): flush=1, busy=1. Go ENTER.
- ENTER (1 cycle):
  - trapTrigger = 1<<cause.
  - mepcWrite=1, mepcOut={epc[N-1:2],2'b00}.
  - mcauseWrite=1, mcauseOut = {isIrq, (N-5)'0, cause[3:0]}.
  - Target: base={mtvec[N-1:2],2'b00}. If mtvec[1:0]==2'b01 and isIrq, target = base + (cause<<2), truncated to N bits. Otherwise target = base.
  - busy=1. Go REDIRECT.
- RETURN (1 cycle): trapReturn=1, flush=1, busy=1. Go REDIRECT.
- REDIRECT:
  - redirectValid=1, redirectPC=target, busy=1, held until redirectAck.
  - In the ack cycle, go IDLE; redirectValid drops the next cycle.
  - If redirectAck is already high on the first REDIRECT cycle, REDIRECT lasts exactly 1 cycle.
- Outside IDLE, new excReq/irq/mretReq are ignored; the sequence is not re-entered.
- Latency for an exception detected at edge T (state enters FLUSH at T):
  - flush visible T..T+1.
  - trapTrigger, mepcWrite, mcauseWrite visible T+1..T+2.
  - redirectValid from T+2.
- Pulse outputs are exactly one cycle wide: trapTrigger, trapReturn, flush, mepcWrite, mcauseWrite.
- Cause codes above 15 are unrepresentable and not handled.

Decomposition:
- Package trap_pkg:
  - state_t enum (IDLE, FLUSH, ENTER, RETURN, REDIRECT).
  - Cause constants: MSI=3, MTI=7, MEI=11, SSI=1, STI=5, SEI=9, ECALL_M=11.
  - Interrupt priority list.
  - MTVEC_VECTORED=2'b01.
  - MSTATUS_MIE=3.
- Sub-module trap_priority_encoder (combinational): excReq, masked irq and takeIrq in; valid, isIrq and cause[3:0] out.

Test Plan:
- Reset: hold reset=0 for 2 edges mid-REDIRECT -> all outputs 0, state IDLE; no trapTrigger after release.
- Exception: excReq=16'h0004, excPC=0x1002, mtvec=0x8000_0001 -> flush 1 cycle, then trapTrigger=0x0004, mepcOut=0x1000, mcauseOut=2, then redirectPC=0x8000_0000 (not vectored for exceptions).
- Vectored interrupt with priority: irqPending=0x0880, irqEnable=0xFFFF, mstatus=0x8, mode=3, mtvec=0x100|1 -> cause 11, mcauseOut=0x8000_0000_0000_000B, redirectPC=0x12C.
- Masking: same interrupt with mstatus=0, mode=3 -> no activity. Then mode=0 -> trap taken, cause 11.
- Return with conflict: mretReq=1, mepcIn=0x4000 alone -> trapReturn pulse, redirectPC=0x4000. mretReq with excReq=0x0001 in the same cycle -> exception entry, no trapReturn.
- Handshake: redirectAck held low 3 cycles -> redirectValid and busy stay 1 with a stable redirectPC; IDLE the cycle after ack.
